// File: rtl/game_seq_pkg.sv
// Shared types and default constants for the game run controller.
package game_seq_pkg;

  typedef enum logic [1:0] {
    WAITING   = 2'd0,
    RUNNING   = 2'd1,
    CRASHED   = 2'd2,
    RESETTING = 2'd3
  } state_t;

  localparam int SPEED_SCALE        = 1024;   // speed fixed-point 1.0
  localparam int DEF_INIT_SPEED     = 6144;
  localparam int DEF_MAX_SPEED      = 13312;
  localparam int DEF_ACCEL          = 1;
  localparam int DEF_UPDATE_GAP     = 4;
  localparam int DEF_CLEAR_FRAMES   = 180;
  localparam int DEF_LOCKOUT_FRAMES = 30;
  localparam int PEND_MAX           = 63;     // limit of the 6-bit timer

  // Speed after an update covering t frames; the wide sum cannot wrap before the clamp.
  function automatic logic [14:0] speed_next(input logic [14:0] spd, input logic [5:0] t,
                                             input int accel, input int max_s);
    logic [20:0] w_sum;
    w_sum = {6'd0, spd} + 21'(accel) * {15'd0, t};
    return (w_sum > 21'(max_s)) ? 15'(max_s) : w_sum[14:0];
  endfunction

endpackage

// File: rtl/game_sequencer_update_pacer.sv
// Collects frame ticks and releases them as update strobes spaced at least GAP cycles apart.
module update_pacer
  import game_seq_pkg::*;
#(
  parameter int GAP = DEF_UPDATE_GAP
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_en,     // ticks only count while enabled
  input  logic       i_flush,  // drops pending frames and the gap, suppresses issue
  input  logic       i_tick,
  output logic       o_update,
  output logic [5:0] o_timer
);

  logic [5:0] r_pend;
  logic [7:0] r_gap;
  logic       w_issue;
  logic       w_tick;

  assign w_tick   = i_en & i_tick;
  assign w_issue  = i_en & ~i_flush & (r_pend != 6'd0) & (r_gap == 8'd0);
  assign o_update = w_issue;
  assign o_timer  = w_issue ? r_pend : 6'd0;

  // Pending frame count and spacing counter; a tick in the issue cycle starts the next batch.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      r_pend <= 6'd0;
      r_gap  <= 8'd0;
    end else if (w_issue) begin
      r_pend <= w_tick ? 6'd1 : 6'd0;
      r_gap  <= 8'(GAP - 1);
    end else begin
      if (w_tick && r_pend != 6'(PEND_MAX)) r_pend <= r_pend + 6'd1;
      if (r_gap != 8'd0) r_gap <= r_gap - 8'd1;
    end
  end

endmodule

// File: rtl/game_sequencer.sv
// Run controller: game FSM, paced horizon updates, speed ramp, obstacle delay, restart lockout.
// Optional macro GAME_SEQ_ACCEL_EN enables the speed ramp; otherwise speed stays at INIT_SPEED.
module game_sequencer
  import game_seq_pkg::*;
#(
  parameter int INIT_SPEED     = DEF_INIT_SPEED,
  parameter int UPDATE_GAP     = DEF_UPDATE_GAP,
  parameter int CLEAR_FRAMES   = DEF_CLEAR_FRAMES,
  parameter int LOCKOUT_FRAMES = DEF_LOCKOUT_FRAMES
`ifdef GAME_SEQ_ACCEL_EN
  ,
  parameter int MAX_SPEED      = DEF_MAX_SPEED,
  parameter int ACCEL          = DEF_ACCEL
`endif
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_frame_tick,
  input  logic        i_start_req,
  input  logic        i_crash_in,
  input  logic        i_restart_req,
  output logic        o_start,
  output logic        o_crash,
  output logic        o_update,
  output logic [5:0]  o_timer,
  output logic [14:0] o_speed,
  output logic        o_has_obstacles,
  output logic        o_game_rst
);

  state_t     r_state, w_next;
  logic [7:0] r_clr;
  logic [7:0] r_lock;
  logic       w_flush;
  logic       w_reload;
  logic [8:0] w_clr_sum;

  assign w_reload = (r_state == RESETTING);
  assign w_flush  = ((r_state == RUNNING) & i_crash_in) | w_reload;

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= WAITING;
    else       r_state <= w_next;
  end

  // Next state and the start pulse
  always_comb begin
    w_next  = r_state;
    o_start = 1'b0;
    case (r_state)
      WAITING:   if (i_start_req) begin
                   w_next  = RUNNING;
                   o_start = 1'b1;
                 end
      RUNNING:   if (i_crash_in) w_next = CRASHED;
      CRASHED:   if (i_restart_req && r_lock == 8'(LOCKOUT_FRAMES)) w_next = RESETTING;
      RESETTING: w_next = WAITING;
      default:   w_next = WAITING;
    endcase
  end

  assign o_crash    = (r_state == CRASHED);
  assign o_game_rst = w_reload;

  update_pacer #(.GAP(UPDATE_GAP)) u_pacer (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_en     (r_state == RUNNING),
    .i_flush  (w_flush),
    .i_tick   (i_frame_tick),
    .o_update (o_update),
    .o_timer  (o_timer)
  );

`ifdef GAME_SEQ_ACCEL_EN
  logic [14:0] r_speed;
  // Speed ramps by the frames each update covers, clamped at MAX_SPEED
  always_ff @(posedge i_clk) begin
    if (i_rst || w_reload) r_speed <= 15'(INIT_SPEED);
    else if (o_update)     r_speed <= speed_next(r_speed, o_timer, ACCEL, MAX_SPEED);
  end
  assign o_speed = r_speed;
`else
  assign o_speed = 15'(INIT_SPEED);
`endif

  assign w_clr_sum = {1'b0, r_clr} + {3'd0, o_timer};

  // Frames survived since start; obstacles are enabled once the runway is clear
  always_ff @(posedge i_clk) begin
    if (i_rst || w_reload) r_clr <= 8'd0;
    else if (o_update)     r_clr <= (w_clr_sum >= 9'(CLEAR_FRAMES)) ? 8'(CLEAR_FRAMES) : w_clr_sum[7:0];
  end

  assign o_has_obstacles = (r_clr == 8'(CLEAR_FRAMES));

  // Frames spent crashed; restart is only honoured after the lockout fills
  always_ff @(posedge i_clk) begin
    if (i_rst || w_reload) r_lock <= 8'd0;
    else if (r_state == CRASHED && i_frame_tick && r_lock != 8'(LOCKOUT_FRAMES))
      r_lock <= r_lock + 8'd1;
  end

endmodule

// File: tb/tb_game_sequencer.sv
// Randomized bench for game_sequencer against a frame-accounting reference model.
module tb_game_sequencer;

  localparam int M_INIT  = 6144;
  localparam int M_MAX   = 13312;
  localparam int M_GAP   = 4;
  localparam int M_CLEAR = 180;
  localparam int M_LOCK  = 30;

  logic        clk = 1'b0;
  logic        i_rst, i_frame_tick, i_start_req, i_crash_in, i_restart_req;
  logic        o_start, o_crash, o_update, o_has_obstacles, o_game_rst;
  logic [5:0]  o_timer;
  logic [14:0] o_speed;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: phase 0 idle, 1 running, 2 crashed, 3 resetting
  int ph, pend, last_upd, cyc, spd, clr, lock;

  game_sequencer dut (
    .i_clk           (clk),
    .i_rst           (i_rst),
    .i_frame_tick    (i_frame_tick),
    .i_start_req     (i_start_req),
    .i_crash_in      (i_crash_in),
    .i_restart_req   (i_restart_req),
    .o_start         (o_start),
    .o_crash         (o_crash),
    .o_update        (o_update),
    .o_timer         (o_timer),
    .o_speed         (o_speed),
    .o_has_obstacles (o_has_obstacles),
    .o_game_rst      (o_game_rst)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0d want %0d", tag, cyc, got, exp);
    end
  endtask

  task automatic m_reset();
    ph = 0; pend = 0; last_upd = -1000; spd = M_INIT; clr = 0; lock = 0;
  endtask

  // Apply one cycle of inputs, check outputs mid-cycle, then advance the model past the edge.
  task automatic step(input bit rst, input bit tick, input bit st, input bit cr, input bit rs);
    bit e_upd;
    int e_tmr;
    @(negedge clk);
    i_rst = rst; i_frame_tick = tick; i_start_req = st; i_crash_in = cr; i_restart_req = rs;
    #1;
    e_upd = (ph == 1) && !cr && pend > 0 && (cyc - last_upd >= M_GAP);
    e_tmr = e_upd ? pend : 0;
    chk("start",  32'(o_start),         32'(ph == 0 && st));
    chk("crash",  32'(o_crash),         32'(ph == 2));
    chk("update", 32'(o_update),        32'(e_upd));
    chk("timer",  32'(o_timer),         32'(e_tmr));
    chk("speed",  32'(o_speed),         32'(spd));
    chk("hasobs", 32'(o_has_obstacles), 32'(clr >= M_CLEAR));
    chk("gamerst",32'(o_game_rst),      32'(ph == 3));
    if (rst) m_reset();
    else begin
      case (ph)
        0: if (st) ph = 1;
        1: if (cr) begin
             ph = 2; pend = 0; last_upd = -1000;
           end else if (e_upd) begin
`ifdef GAME_SEQ_ACCEL_EN
             spd = (spd + e_tmr > M_MAX) ? M_MAX : spd + e_tmr;
`endif
             clr = (clr + e_tmr > M_CLEAR) ? M_CLEAR : clr + e_tmr;
             pend = tick ? 1 : 0;
             last_upd = cyc;
           end else if (tick && pend < 63) pend++;
        2: begin
             if (rs && lock == M_LOCK) ph = 3;
             if (tick && lock < M_LOCK) lock++;
           end
        default: m_reset();
      endcase
    end
    cyc++;
  endtask

  initial begin
    int guard;
    cyc = 0;
    i_rst = 1'b1; i_frame_tick = 1'b0; i_start_req = 1'b0; i_crash_in = 1'b0; i_restart_req = 1'b0;
    repeat (3) @(negedge clk);
    m_reset();
    // Reset state, then ticks without start: nothing moves
    for (int i = 0; i < 30; i++) step(0, (i % 10) == 0, 0, 0, 0);
    // Start, then widely spaced ticks: one-frame updates
    step(0, 0, 1, 0, 0);
    for (int k = 0; k < 8; k++)
      for (int j = 0; j < 20; j++) step(0, j == 0, 0, 0, 0);
    // Three ticks inside the gap right after an update
    step(0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    repeat (3) step(0, 1, 0, 0, 0);
    repeat (10) step(0, 0, 0, 0, 0);
    // Run until the obstacle delay expires
    guard = 0;
    while (clr < M_CLEAR && guard < 5000) begin
      step(0, $urandom_range(0, 3) == 0, 0, 0, 0);
      guard++;
    end
    chk("clear_reached", 32'(guard < 5000), 32'd1);
    repeat (20) step(0, $urandom_range(0, 1), 0, 0, 0);
    // Crash in the cycle an update would issue
    repeat (10) step(0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 1, 0);
    // Restart during lockout is ignored, honoured once it fills
    for (int i = 0; i < 10; i++) begin
      step(0, 1, 0, 0, 0);
      step(0, 0, 0, 0, 0);
    end
    step(0, 0, 0, 0, 1);
    for (int i = 0; i < 20; i++) begin
      step(0, 1, 0, 0, 0);
      step(0, 0, 0, 0, 0);
    end
    step(0, 0, 0, 0, 1);
    repeat (5) step(0, 0, 0, 0, 0);
    // Long run with a tick every cycle drives speed into the clamp
    step(0, 0, 1, 0, 0);
    repeat (7400) step(0, 1, 0, 0, 0);
    repeat (3) step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0);  // reset mid-game
    step(0, 0, 0, 0, 0);
    // Random traffic across every state
    repeat (3000)
      step($urandom_range(0, 499) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0,
           $urandom_range(0, 39) == 0, $urandom_range(0, 9) == 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
